// File: rtl/nl_prng_core.sv
// Nonlinear PRNG core: N-bit state stepped by an additive, quadratic or Galois LFSR rule,
// with seeding and orbit-period measurement. Optional step prescaler under NL_PRNG_PRESCALE_EN.
module nl_prng_core #(
  parameter int                 WIDTH    = 8,
  parameter int                 PW       = 16,
  parameter logic [WIDTH-1:0]   TAPS     = WIDTH'(8'hB8),
  parameter int                 PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_seed_load,
  input  logic [WIDTH-1:0] i_seed,
  input  logic [WIDTH-1:0] i_x_in,
  output logic [WIDTH-1:0] o_state_out,
  output logic             o_out_valid,
  output logic [PW-1:0]    o_period,
  output logic             o_period_done,
  output logic             o_period_ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} fsm_t;

  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]    CNT_LAST = {{(PW-1){1'b1}}, 1'b0};
  localparam logic [PW-1:0]    CNT_MAX  = {PW{1'b1}};

  fsm_t             r_fsm, w_fsm_nxt;
  logic [WIDTH-1:0] r_state, r_seed;
  logic [PW-1:0]    r_cnt, r_period;
  logic             r_valid, r_done, r_ovf;
  logic             w_qual, w_step;
  logic [WIDTH-1:0] w_sq, w_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_nxt;
    end
  end

  always_comb begin
    w_fsm_nxt = r_fsm;
    case (r_fsm)
      IDLE:    w_fsm_nxt = i_seed_load ? RUN : IDLE;
      RUN:     w_fsm_nxt = RUN;
      default: w_fsm_nxt = IDLE;
    endcase
  end

  assign w_qual = (r_fsm == RUN) && i_en && !i_seed_load && (i_mode != 2'b11);

`ifdef NL_PRNG_PRESCALE_EN
  localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PRESCALE - 1);
  logic [DW-1:0] r_div;

  // Divider only advances on qualifying cycles, so HOLD or en=0 simply stretches the interval.
  always_ff @(posedge clk) begin
    if (reset || i_seed_load) begin
      r_div <= {DW{1'b0}};
    end else if (w_qual) begin
      r_div <= (r_div == DIV_LAST) ? {DW{1'b0}} : r_div + DW'(1);
    end else begin
      r_div <= r_div;
    end
  end

  assign w_step = w_qual && (r_div == DIV_LAST);
`else
  assign w_step = w_qual;
`endif

  assign w_sq = r_state * r_state;

  always_comb begin
    w_next = r_state;
    case (i_mode)
      2'b00: w_next = r_state + i_x_in;
      2'b01: w_next = r_state + i_x_in + w_sq;
      2'b10: begin
        if (r_state == W_ZERO) begin
          w_next = W_ONE;
        end else begin
          w_next = (r_state >> 1) ^ (r_state[0] ? TAPS : W_ZERO);
        end
      end
      default: w_next = r_state;
    endcase
  end

  // Period bookkeeping freezes once done; the state itself keeps stepping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= W_ZERO;
      r_seed   <= W_ZERO;
      r_cnt    <= {PW{1'b0}};
      r_period <= {PW{1'b0}};
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (i_seed_load) begin
      r_state  <= i_seed;
      r_seed   <= i_seed;
      r_cnt    <= {PW{1'b0}};
      r_period <= {PW{1'b0}};
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= w_step;
      if (w_step) begin
        r_state <= w_next;
        if (!r_done) begin
          if (w_next == r_seed) begin
            r_period <= r_cnt + PW'(1);
            r_done   <= 1'b1;
          end else if (r_cnt == CNT_LAST) begin
            r_period <= CNT_MAX;
            r_done   <= 1'b1;
            r_ovf    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + PW'(1);
          end
        end
      end
    end
  end

  assign o_state_out   = r_state;
  assign o_out_valid   = r_valid;
  assign o_period      = r_period;
  assign o_period_done = r_done;
  assign o_period_ovf  = r_ovf;

endmodule

// File: tb/tb_nl_prng_core.sv
// Scoreboard bench for nl_prng_core (WIDTH=8, PW=16, TAPS=8'hB8); follows NL_PRNG_PRESCALE_EN if defined.
module tb_nl_prng_core;

`ifdef NL_PRNG_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, en, seed_load;
  logic [1:0]  mode;
  logic [7:0]  seed, x_in;
  logic [7:0]  state_out;
  logic        out_valid, period_done, period_ovf;
  logic [15:0] period;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]  st;
    logic        v;
    logic [15:0] per;
    logic        done;
    logic        ovf;
  } exp_t;
  exp_t q[$];

  // independent reference model state
  logic        m_run;
  logic [7:0]  m_state, m_seed;
  int          m_cnt, m_div;
  logic [15:0] m_period;
  logic        m_valid, m_done, m_ovf;

  nl_prng_core #(.WIDTH(8), .PW(16), .TAPS(8'hB8), .PRESCALE(4)) dut (
    .clk(clk), .reset(reset), .i_en(en), .i_mode(mode), .i_seed_load(seed_load),
    .i_seed(seed), .i_x_in(x_in), .o_state_out(state_out), .o_out_valid(out_valid),
    .o_period(period), .o_period_done(period_done), .o_period_ovf(period_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_next(input logic [1:0] md, input logic [7:0] s, input logic [7:0] x);
    logic [15:0] sq;
    sq = s * s;
    case (md)
      2'b00:   return s + x;
      2'b01:   return s + x + sq[7:0];
      2'b10:   return (s == 8'd0) ? 8'd1 : ({1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00));
      default: return s;
    endcase
  endfunction

  task automatic model_edge();
    logic       stp;
    logic [7:0] nx;
    if (reset) begin
      m_run = 1'b0; m_state = 8'd0; m_seed = 8'd0; m_cnt = 0; m_div = 0;
      m_period = 16'd0; m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else if (seed_load) begin
      m_run = 1'b1; m_state = seed; m_seed = seed; m_cnt = 0; m_div = 0;
      m_period = 16'd0; m_valid = 1'b0; m_done = 1'b0; m_ovf = 1'b0;
    end else begin
      stp = m_run && en && (mode != 2'b11);
      if (stp && PS > 1) begin
        if (m_div == PS - 1) m_div = 0;
        else begin
          m_div = m_div + 1;
          stp = 1'b0;
        end
      end
      m_valid = stp;
      if (stp) begin
        nx = ref_next(mode, m_state, x_in);
        m_state = nx;
        if (!m_done) begin
          if (nx == m_seed) begin
            m_period = 16'(m_cnt + 1); m_done = 1'b1;
          end else if (m_cnt == 65534) begin
            m_period = 16'hFFFF; m_done = 1'b1; m_ovf = 1'b1;
          end else m_cnt = m_cnt + 1;
        end
      end
    end
  endtask

  // One clock: predict, push, clock, pop and compare.
  task automatic cycle();
    exp_t e;
    model_edge();
    e.st = m_state; e.v = m_valid; e.per = m_period; e.done = m_done; e.ovf = m_ovf;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    check("state_out", state_out, e.st);
    check("out_valid", out_valid, e.v);
    check("period", period, e.per);
    check("period_done", period_done, e.done);
    check("period_ovf", period_ovf, e.ovf);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (out_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_valid_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (period_done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    check({tag, "_done_timeout"}, 32'(ok), 32'd1);
  endtask

  task automatic load(input logic [7:0] s, input logic [1:0] md);
    seed_load = 1'b1; seed = s; mode = md;
    cycle();
    seed_load = 1'b0;
  endtask

  logic [7:0] quad_seq [5] = '{8'd1, 8'd3, 8'd13, 8'd183, 8'd137};
  int gap;

  initial begin
    reset = 1'b1; en = 1'b0; mode = 2'b00; seed_load = 1'b0; seed = 8'd0; x_in = 8'd0;
    repeat (2) cycle();
    reset = 1'b0;

    // 1: no seed yet, en ignored
    en = 1'b1; mode = 2'b01;
    repeat (10) cycle();
    check("idle_state", state_out, 8'd0);
    check("idle_valid", out_valid, 1'b0);

    // 2: quadratic sequence from seed 0
    en = 1'b0; x_in = 8'd1;
    load(8'd0, 2'b01);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid("quad", 2 * PS + 2);
      check("quad_seq", state_out, quad_seq[i]);
    end

    // 3: additive orbit of length 256
    en = 1'b0;
    load(8'd0, 2'b00);
    en = 1'b1;
    wait_done("acc", 300 * PS);
    check("acc_period", period, 16'd256);
    check("acc_ovf", period_ovf, 1'b0);
    check("acc_state", state_out, 8'd0);
    repeat (3 * PS) cycle();
    check("acc_frozen", period, 16'd256);

    // 4: maximal Galois LFSR, then lock-up escape
    en = 1'b0;
    load(8'd1, 2'b10);
    en = 1'b1;
    wait_done("lfsr", 300 * PS);
    check("lfsr_period", period, 16'd255);
    en = 1'b0;
    load(8'd0, 2'b10);
    en = 1'b1;
    wait_valid("lfsr0", 2 * PS + 2);
    check("lfsr_escape", state_out, 8'd1);

    // 5: seed_load beats en mid-run, then reset mid-run
    repeat (5) cycle();
    seed_load = 1'b1; seed = 8'h5A;
    cycle();
    seed_load = 1'b0;
    check("reseed_state", state_out, 8'h5A);
    check("reseed_valid", out_valid, 1'b0);
    check("reseed_done", period_done, 1'b0);
    mode = 2'b00; x_in = 8'd7;
    repeat (6) cycle();
    reset = 1'b1;
    cycle();
    check("rst_state", state_out, 8'd0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_period", period, 16'd0);
    reset = 1'b0;
    repeat (6) cycle();
    check("post_rst_state", state_out, 8'd0);

    // 6: step spacing and HOLD stretching
    x_in = 8'd1;
    load(8'd0, 2'b00);
    wait_valid("ps", 2 * PS + 2);
    gap = 0;
    do begin
      cycle(); gap++;
    end while (out_valid !== 1'b1 && gap < 20);
    check("step_gap", 32'(gap), 32'(PS));
    mode = 2'b11;
    cycle(); cycle();
    mode = 2'b00;
    gap = 2;
    do begin
      cycle(); gap++;
    end while (out_valid !== 1'b1 && gap < 20);
    check("hold_gap", 32'(gap), 32'(PS + 2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
